// File: rtl/iobuf_pkg.sv
// Shared types and constants for the GPIO pad power/hold sequencer.
package iobuf_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWRWAIT = 3'd1,
        ST_ENABLE  = 3'd2,
        ST_RUN     = 3'd3,
        ST_HOLD    = 3'd4,
        ST_APPLY   = 3'd5
    } state_t;

    // Bit positions inside a pad cfg byte; ds occupies bits 7:4.
    localparam int CFG_PULL_EN = 0;
    localparam int CFG_PULL_UP = 1;
    localparam int CFG_SLEW    = 2;
    localparam int CFG_SCHMITT = 3;
    localparam int CFG_DS_LSB  = 4;

endpackage

// File: rtl/iobuf_seq_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module iobuf_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load on request, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/iobuf_seq.sv
// Power-up / hold sequencer for a bank of GPIO pads with per-pad cfg writes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OFF     | supplies not good: ENABLE_H low, all pads held
// PWRWAIT | supplies good, waiting PWR_WAIT+1 cycles
// ENABLE  | ENABLE_H high, pads still held for HOLD_WAIT cycles
// RUN     | pads operational, cfg write requests accepted
// HOLD    | target pad held for HOLD_WAIT cycles before its cfg changes
// APPLY   | new cfg byte visible, pad still held for one more cycle
module iobuf_seq
    import iobuf_pkg::*;
#(
    parameter int         NPADS     = 8,
    parameter int         PWR_WAIT  = 16,
    parameter int         HOLD_WAIT = 4,
    parameter logic [7:0] CFG_RST   = 8'h00,
    localparam int        PW        = (NPADS < 2) ? 1 : $clog2(NPADS)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 por_ok,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PW-1:0]        req_pad,
    input  logic [7:0]           req_cfg,
    output logic                 enable_h,
    output logic [NPADS-1:0]     hld_h_n,
    output logic [NPADS*8-1:0]   cfg,
    output logic                 ready,
    output logic                 err
);

    localparam int TMAX = (PWR_WAIT > HOLD_WAIT) ? PWR_WAIT : HOLD_WAIT;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
    localparam logic [PW:0] PAD_LIMIT = NPADS[PW:0];

    state_t           state;
    state_t           next_state;
    logic             run_en;
    logic [PW-1:0]    pad_q;
    logic [7:0]       byte_q;
    logic             pad_ok;
    logic [PW-1:0]    pad_sel;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_done;
    logic             enable_d;
    logic [NPADS-1:0] hld_d;
    logic             err_d;

    assign pad_ok    = ({1'b0, req_pad} < PAD_LIMIT);
    assign req_ready = (state == ST_RUN);
    // While in RUN the pad about to be held is the one being requested.
    assign pad_sel   = (state == ST_RUN) ? req_pad : pad_q;

    iobuf_seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .nreset   (nreset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Reset release is only acted on one edge later, keeping the FSM in OFF.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    // Next-state decode plus the values the registered outputs take with it.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = TW'(HOLD_WAIT - 1);
        enable_d   = 1'b0;
        hld_d      = '0;
        err_d      = 1'b0;

        if (!run_en) begin
            next_state = ST_OFF;
        end else if (state != ST_OFF && !por_ok) begin
            next_state = ST_OFF;
        end else begin
            case (state)
                ST_OFF:     if (por_ok) next_state = ST_PWRWAIT;
                ST_PWRWAIT: if (tmr_done) next_state = ST_ENABLE;
                ST_ENABLE:  if (tmr_done) next_state = ST_RUN;
                ST_RUN: begin
                    if (req_valid) begin
                        if (pad_ok) next_state = ST_HOLD;
                        else        err_d = 1'b1;
                    end
                end
                ST_HOLD:    if (tmr_done) next_state = ST_APPLY;
                ST_APPLY:   next_state = ST_RUN;
                default:    next_state = ST_OFF;
            endcase
        end

        if (next_state != state) begin
            tmr_load = 1'b1;
            if (next_state == ST_PWRWAIT) tmr_val = TW'(PWR_WAIT);
        end

        case (next_state)
            ST_ENABLE: enable_d = 1'b1;
            ST_RUN: begin
                enable_d = 1'b1;
                hld_d    = '1;
            end
            ST_HOLD, ST_APPLY: begin
                enable_d = 1'b1;
                for (int p = 0; p < NPADS; p++) hld_d[p] = (PW'(p) != pad_sel);
            end
            default: ;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= ST_OFF;
            enable_h <= 1'b0;
            hld_h_n  <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= next_state;
            enable_h <= enable_d;
            hld_h_n  <= hld_d;
            ready    <= (next_state == ST_RUN);
            err      <= err_d;
        end
    end

    // Capture an accepted request; the byte only reaches cfg on entering APPLY.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pad_q  <= '0;
            byte_q <= '0;
        end else if (state == ST_RUN && next_state == ST_HOLD) begin
            pad_q  <= req_pad;
            byte_q <= req_cfg;
        end
    end

    // Per-pad cfg bytes, updated only after the full hold interval.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cfg <= {NPADS{CFG_RST}};
        end else if (state == ST_HOLD && next_state == ST_APPLY) begin
            for (int p = 0; p < NPADS; p++) begin
                if (PW'(p) == pad_q) cfg[p*8 +: 8] <= byte_q;
            end
        end
    end

endmodule

// File: tb/tb_iobuf_seq.sv
// Directed bench for iobuf_seq: power-up, cfg writes, bad index, POR drop, async reset.
module tb_iobuf_seq;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        por_ok = 1'b1;

    logic        req_valid = 1'b0;
    logic [2:0]  req_pad = '0;
    logic [7:0]  req_cfg = '0;
    logic        req_ready;
    logic        enable_h;
    logic [7:0]  hld_h_n;
    logic [63:0] cfg;
    logic        ready;
    logic        err;

    logic        req_valid6 = 1'b0;
    logic [2:0]  req_pad6 = '0;
    logic [7:0]  req_cfg6 = '0;
    logic        req_ready6;
    logic        enable_h6;
    logic [5:0]  hld_h_n6;
    logic [47:0] cfg6;
    logic        ready6;
    logic        err6;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] cfg_m = '0;

    always #5 clk = ~clk;

    iobuf_seq dut (
        .clk(clk), .nreset(nreset), .por_ok(por_ok),
        .req_valid(req_valid), .req_ready(req_ready), .req_pad(req_pad), .req_cfg(req_cfg),
        .enable_h(enable_h), .hld_h_n(hld_h_n), .cfg(cfg), .ready(ready), .err(err)
    );

    iobuf_seq #(.NPADS(6)) dut6 (
        .clk(clk), .nreset(nreset), .por_ok(por_ok),
        .req_valid(req_valid6), .req_ready(req_ready6), .req_pad(req_pad6), .req_cfg(req_cfg6),
        .enable_h(enable_h6), .hld_h_n(hld_h_n6), .cfg(cfg6), .ready(ready6), .err(err6)
    );

    typedef struct {
        logic [2:0] pad;
        logic [7:0] cfgb;
        logic [7:0] hld_exp;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges until enable_h rises and until pads run; -1 if never within budget.
    task automatic count_seq(output int en_edge, output int run_edge);
        en_edge  = -1;
        run_edge = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (enable_h && en_edge < 0) en_edge = i;
            if (hld_h_n == 8'hFF && ready && run_edge < 0) run_edge = i;
            if (run_edge >= 0) break;
        end
    endtask

    initial begin
        int en_e;
        int run_e;
        int n;

        vecs[0] = '{pad: 3'd3, cfgb: 8'hA5, hld_exp: 8'hF7};
        vecs[1] = '{pad: 3'd0, cfgb: 8'h3C, hld_exp: 8'hFE};
        vecs[2] = '{pad: 3'd7, cfgb: 8'hFF, hld_exp: 8'h7F};
        vecs[3] = '{pad: 3'd3, cfgb: 8'h5A, hld_exp: 8'hF7};

        // Reset state
        tick();
        tick();
        chk("rst_enable_h", 64'(enable_h), 64'd0);
        chk("rst_hld_h_n", 64'(hld_h_n), 64'h00);
        chk("rst_cfg", cfg, 64'h0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);

        // Power-up: one sync edge, one edge into PWRWAIT, then 17 PWRWAIT cycles.
        nreset = 1'b1;
        count_seq(en_e, run_e);
        chk("pwrup_enable_edge", 64'(en_e), 64'd19);
        chk("pwrup_run_edge", 64'(run_e), 64'd23);
        chk("pwrup_req_ready", 64'(req_ready), 64'd1);
        chk("pwrup6_ready", 64'(ready6), 64'd1);
        chk("pwrup6_hld", 64'(hld_h_n6), 64'h3F);

        // Table-driven cfg writes
        for (int v = 0; v < 4; v++) begin
            req_valid = 1'b1;
            req_pad   = vecs[v].pad;
            req_cfg   = vecs[v].cfgb;
            tick();
            req_valid = 1'b0;
            req_cfg   = 8'h00;
            for (int k = 1; k <= 5; k++) begin
                if (k > 1) tick();
                if (k == 5) cfg_m[int'(vecs[v].pad)*8 +: 8] = vecs[v].cfgb;
                chk($sformatf("vec%0d_k%0d_hld", v, k), 64'(hld_h_n), 64'(vecs[v].hld_exp));
                chk($sformatf("vec%0d_k%0d_cfg", v, k), cfg, cfg_m);
                chk($sformatf("vec%0d_k%0d_ready", v, k), 64'(ready), 64'd0);
            end
            tick();
            chk($sformatf("vec%0d_done_hld", v), 64'(hld_h_n), 64'hFF);
            chk($sformatf("vec%0d_done_req_ready", v), 64'(req_ready), 64'd1);
        end

        // Bad index on the 6-pad instance, then a good write as contrast
        req_valid6 = 1'b1;
        req_pad6   = 3'd7;
        req_cfg6   = 8'h99;
        chk("bad_req_ready_pre", 64'(req_ready6), 64'd1);
        tick();
        chk("bad7_err", 64'(err6), 64'd1);
        chk("bad7_hld", 64'(hld_h_n6), 64'h3F);
        chk("bad7_req_ready", 64'(req_ready6), 64'd1);
        req_pad6 = 3'd6;
        tick();
        chk("bad6_err", 64'(err6), 64'd1);
        chk("bad6_cfg", 64'(cfg6), 64'h0);
        req_valid6 = 1'b0;
        tick();
        chk("bad_err_clear", 64'(err6), 64'd0);
        chk("bad_cfg_kept", 64'(cfg6), 64'h0);
        chk("bad_hld_kept", 64'(hld_h_n6), 64'h3F);
        chk("bad_ready_kept", 64'(ready6), 64'd1);
        req_valid6 = 1'b1;
        req_pad6   = 3'd5;
        req_cfg6   = 8'h3C;
        tick();
        req_valid6 = 1'b0;
        chk("good5_err", 64'(err6), 64'd0);
        chk("good5_hld", 64'(hld_h_n6), 64'h1F);
        repeat (5) tick();
        chk("good5_cfg", 64'(cfg6), 64'h3C00_0000_0000);
        chk("good5_hld_done", 64'(hld_h_n6), 64'h3F);

        // Back-to-back with req_valid held
        req_valid = 1'b1;
        req_pad   = 3'd1;
        req_cfg   = 8'h11;
        tick();
        req_pad = 3'd2;
        req_cfg = 8'h22;
        chk("b2b_first_hld", 64'(hld_h_n), 64'hFD);
        n = 1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_gap", 64'(n), 64'd6);
        cfg_m[15:8] = 8'h11;
        chk("b2b_first_cfg", cfg, cfg_m);
        tick();
        req_valid = 1'b0;
        chk("b2b_second_hld", 64'(hld_h_n), 64'hFB);
        repeat (4) tick();
        cfg_m[23:16] = 8'h22;
        chk("b2b_second_cfg", cfg, cfg_m);
        tick();
        chk("b2b_done_hld", 64'(hld_h_n), 64'hFF);

        // POR drop mid-HOLD discards the in-flight byte
        req_valid = 1'b1;
        req_pad   = 3'd3;
        req_cfg   = 8'hC3;
        tick();
        req_valid = 1'b0;
        tick();
        por_ok = 1'b0;
        tick();
        chk("por_enable_1", 64'(enable_h), 64'd0);
        chk("por_hld_1", 64'(hld_h_n), 64'h00);
        tick();
        chk("por_enable_2", 64'(enable_h), 64'd0);
        chk("por_hld_2", 64'(hld_h_n), 64'h00);
        chk("por_ready", 64'(ready), 64'd0);
        chk("por_req_ready", 64'(req_ready), 64'd0);
        chk("por_cfg_kept", cfg, cfg_m);
        por_ok = 1'b1;
        count_seq(en_e, run_e);
        chk("repwr_enable_edge", 64'(en_e), 64'd18);
        chk("repwr_run_edge", 64'(run_e), 64'd22);
        chk("repwr_cfg_kept", cfg, cfg_m);

        // Async reset mid-APPLY
        req_valid = 1'b1;
        req_pad   = 3'd5;
        req_cfg   = 8'hE1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        cfg_m[47:40] = 8'hE1;
        chk("apply_cfg", cfg, cfg_m);
        chk("apply_hld", 64'(hld_h_n), 64'hDF);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_cfg", cfg, 64'h0);
        chk("arst_enable_h", 64'(enable_h), 64'd0);
        chk("arst_hld", 64'(hld_h_n), 64'h00);
        chk("arst_ready", 64'(ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iobuf_seq.md
IOBUF_SEQ -- requirements
Module: iobuf_seq

Interface
REQ-001 The module SHALL have parameter NPADS, default 8, meaning the number of sky130 GPIO pads controlled (1..32).
REQ-002 The module SHALL have parameter PWR_WAIT, default 16, meaning the cycles por_ok must stay high before pad enable.
REQ-003 The module SHALL have parameter HOLD_WAIT, default 4, meaning the cycles hold is asserted before and after enable, and before each cfg change (>=1).
REQ-004 The module SHALL have parameter CFG_RST, default 8'h00, meaning the reset value of every pad cfg byte.
REQ-005 The module SHALL have one clock and an asynchronous, active-low reset, with ports clk (input, 1, clock) and nreset (input, 1, async active-low reset).
REQ-006 The module SHALL have input por_ok, width 1, meaning core/IO supplies are good (synchronous to clk).
REQ-007 The module SHALL have input req_valid, width 1, meaning a pad cfg write request is present.
REQ-008 The module SHALL have output req_ready, width 1, meaning a request is accepted this cycle.
REQ-009 The module SHALL have input req_pad, width $clog2(NPADS) rounded up to a minimum of 1, meaning the target pad index.
REQ-010 The module SHALL have input req_cfg, width 8, meaning the new cfg byte (bit0 pull_en, bit1 pull_up, bit2 slew, bit3 schmitt, bits7:4 ds).
REQ-011 The module SHALL have output enable_h, width 1, meaning pad ENABLE_H drive (shared by all pads).
REQ-012 The module SHALL have output hld_h_n, width NPADS, meaning per-pad HLD_H_N (0 = hold).
REQ-013 The module SHALL have output cfg, width NPADS*8, meaning the per-pad cfg byte, with pad p at bits [8p+7:8p].
REQ-014 The module SHALL have output ready, width 1, meaning pads are operational (state RUN).
REQ-015 The module SHALL have output err, width 1, meaning a one-cycle pulse when a request with req_pad>=NPADS is accepted.

Function
REQ-016 The FSM SHALL have states OFF, PWRWAIT, ENABLE, RUN, HOLD and APPLY.
REQ-017 In OFF, the block SHALL drive enable_h=0 and hld_h_n all 0, and SHALL go to PWRWAIT when por_ok=1.
REQ-018 In PWRWAIT, the block SHALL count PWR_WAIT cycles and then go to ENABLE.
REQ-019 In ENABLE, the block SHALL drive enable_h=1 with hld_h_n all 0 for HOLD_WAIT cycles, then go to RUN.
REQ-020 In RUN, the block SHALL drive enable_h=1, hld_h_n all 1, ready=1 and req_ready=1.
REQ-021 req_ready SHALL be a combinational decode of state==RUN only and SHALL NOT depend on req_valid.
REQ-022 When a request with req_pad=p<NPADS is accepted at cycle T (req_valid and req_ready), the block SHALL capture req_pad and req_cfg and enter HOLD at T+1.
REQ-023 In HOLD, the block SHALL drive hld_h_n[p]=0 for cycles T+1..T+HOLD_WAIT, keep other pads at 1, and keep ready=0.
REQ-024 At T+HOLD_WAIT+1, the block SHALL be in APPLY, cfg[p] SHALL show the captured byte, and hld_h_n[p] SHALL still be 0.
REQ-025 At T+HOLD_WAIT+2, the block SHALL return to RUN, drive hld_h_n[p]=1, and assert req_ready=1.
REQ-026 A request with req_pad>=NPADS that is accepted SHALL pulse err at T+1, stay in RUN, leave cfg and hld_h_n unchanged, and keep req_ready high.
REQ-027 If por_ok=0 in any state other than OFF, the block SHALL go to OFF at the next edge; enable_h and hld_h_n SHALL be 0 one cycle later; cfg SHALL be retained; a captured in-flight cfg byte SHALL be discarded.
REQ-028 Counters SHALL restart from 0 on every state entry and SHALL saturate, never wrap.
REQ-029 The block SHALL support PWR_WAIT=0, in which case PWRWAIT lasts exactly 1 cycle.
REQ-030 All outputs except req_ready SHALL be registered.

Reset
REQ-031 When nreset is low, the block SHALL asynchronously force state=OFF, enable_h=0, hld_h_n all 0, cfg all CFG_RST, ready=0, err=0 and counters 0.
REQ-032 Reset de-assertion SHALL be used synchronously, with the first transition allowed at the second clk edge after release.
REQ-033 An nreset assertion during HOLD or APPLY SHALL abort the operation with no partial cfg update.

Structure
REQ-034 A shared package iobuf_pkg SHALL hold the FSM state enum and the cfg bit-position constants (CFG_PULL_EN=0, CFG_PULL_UP=1, CFG_SLEW=2, CFG_SCHMITT=3, CFG_DS_LSB=4).
REQ-035 The design SHALL use one sub-module, iobuf_seq_timer: a loadable, saturating down-counter with a done flag, reused for PWR_WAIT and HOLD_WAIT.
REQ-036 The RTL SHALL contain no latches and no logic outside the clk domain.

Verification
REQ-037 Power-up: with nreset released and por_ok=1 from cycle 0, the bench SHALL check enable_h rises after PWR_WAIT (16) + 1 cycles, hld_h_n goes to 8'hFF HOLD_WAIT (4) cycles later, and ready=1.
REQ-038 Cfg write: in RUN with req_pad=3 and req_cfg=8'hA5 for one cycle, the bench SHALL check hld_h_n=8'hF7 for 5 cycles, cfg[31:24]=8'hA5 on the 5th, hld_h_n=8'hFF and req_ready=1 on the 6th.
REQ-039 Bad index: with NPADS=6 and req_pad=7, the bench SHALL check err pulses 1 cycle, cfg is unchanged, and hld_h_n stays all 1.
REQ-040 POR drop: with por_ok=0 asserted mid-HOLD, the bench SHALL check OFF is reached, enable_h=0 and hld_h_n=0 within 2 cycles, the old cfg byte is retained, and re-power resequences fully.
REQ-041 Async reset: with nreset asserted mid-APPLY, the bench SHALL check cfg returns to CFG_RST immediately, without a clock edge.
REQ-042 Back-to-back requests: with req_valid held high and 2 different pads, the bench SHALL check the second request is accepted exactly HOLD_WAIT+2 cycles after the first.
